// File: rtl/asi_fetch_pkg.sv
// Shared types and constants for the asi instruction fetch stage.
package asi_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [7:0] OP_J   = 8'h01;
    localparam logic [7:0] OP_JAL = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    // Unconditional jumps whose target is encoded in the low 24 bits.
    function automatic logic is_jump(input logic [XLEN-1:0] word);
        return (word[31:24] == OP_J) || (word[31:24] == OP_JAL);
    endfunction

endpackage

// File: rtl/asi_fetch_if.sv
// Fetch-stage bus: instruction memory read port plus core delivery/redirect.
interface asi_fetch_if;
    import asi_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic [XLEN-1:0] instruction;
    logic            write_enable;
    logic [XLEN-1:0] pc;

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr, instruction, write_enable, pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
    );

    // Memory/core environment side.
    modport slave (
        input  imem_req, imem_addr, instruction, write_enable, pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
    );

endinterface

// File: rtl/asi_fetch_fifo.sv
// Prefetch queue with flush; the head entry and its valid flag are registered.
module asi_fetch_fifo
    import asi_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  fetch_entry_t                push_data_i,
    input  logic                        pop_i,
    output fetch_entry_t                head_o,
    output logic                        valid_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d, left_c;
    fetch_entry_t   head_q, head_d;
    logic           valid_q, valid_d;
    logic           push_c, pop_c;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;
    assign valid_o = valid_q;

    // Pointer/occupancy update and selection of the next head entry.
    always_comb begin
        pop_c    = pop_i && !empty_o;
        push_c   = push_i && (!full_o || pop_c);
        left_c   = count_q - CW'(pop_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        valid_d  = valid_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop_c);
            wr_ptr_d = wr_ptr_q + AW'(push_c);
            count_d  = left_c + CW'(push_c);
            if (left_c != '0) begin
                head_d  = mem_q[rd_ptr_d];
                valid_d = 1'b1;
            end else if (push_c) begin
                head_d  = push_data_i;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Entry storage; contents need no reset, occupancy tracks validity.
    always_ff @(posedge clock) begin
        if (push_c && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Control and head registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/asi_fetch.sv
// Instruction fetch stage for the asi core: one outstanding imem read,
// prefetch queue, redirect handling with stale-ack draining.
// Optional: define ASI_FETCH_PREDECODE_EN to follow J/JAL targets at push time.
module asi_fetch
    import asi_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    asi_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] next_pc_c;
    logic            push_c, pop_c, space_c, outstanding_c;
    logic            full_c, empty_c, head_valid_c;
    logic [CW-1:0]   count_c;
    fetch_entry_t    head_c;

    assign outstanding_c = (state_q != IDLE);
    assign space_c       = (32'(count_c) + 32'(outstanding_c)) < FIFO_DEPTH;
    assign pop_c         = !empty_c && !bus.stall;

    asi_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (push_c),
        .push_data_i ('{pc: fetch_pc_q, word: bus.imem_rdata}),
        .pop_i       (pop_c),
        .head_o      (head_c),
        .valid_o     (head_valid_c),
        .count_o     (count_c),
        .full_o      (full_c),
        .empty_o     (empty_c)
    );

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = addr_q;
    assign bus.instruction  = head_c.word;
    assign bus.pc           = head_c.pc;
    assign bus.write_enable = head_valid_c;

    // Fetch FSM next state; redirect outranks push, stale acks are dropped.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push_c     = 1'b0;
        next_pc_c  = fetch_pc_q + XLEN'(1);
`ifdef ASI_FETCH_PREDECODE_EN
        if (is_jump(bus.imem_rdata)) begin
            next_pc_c = {8'h00, bus.imem_rdata[23:0]};
        end
`endif
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
        end
        case (state_q)
            IDLE: begin
                if (bus.redirect_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = bus.redirect_pc;
                end else if (space_c) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    // Request stays up at the old address until its ack drains.
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    push_c     = !full_c;
                    fetch_pc_d = next_pc_c;
                    state_d    = IDLE;
                    req_d      = 1'b0;
                end
            end
            DRAIN: begin
                // Queue was flushed, so the new fetch can issue right after the stale ack.
                if (bus.imem_ack) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // FSM, PC and memory-request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule
